// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two prioritised write ports and a hardware clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [NUM_RD*ADDR_W-1:0]   RAddr,
  output logic [NUM_RD*DATA_W-1:0]   RData,
  input  logic                       WEn0,
  input  logic [ADDR_W-1:0]          WAddr0,
  input  logic [DATA_W-1:0]          WData0,
  input  logic                       WEn1,
  input  logic [ADDR_W-1:0]          WAddr1,
  input  logic [DATA_W-1:0]          WData1,
  input  logic                       Init,
  output logic                       Ready,
  output logic                       WConflict
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  logic              state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic run;
  logic wr_ok;
  logic en0;
  logic en1;
  logic same_addr;

  // Writes only land in RUN on cycles that are not being turned into a re-clear.
  assign run       = (state == ST_RUN);
  assign wr_ok     = run && !Init;
  assign en0       = WEn0 && !(ZERO_REG != 0 && WAddr0 == '0);
  assign en1       = WEn1 && !(ZERO_REG != 0 && WAddr1 == '0);
  assign same_addr = (WAddr0 == WAddr1);
  assign Ready     = run;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      if (ptr == LAST) begin
        state <= ST_RUN;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end else if (Init) begin
      state <= ST_INIT;
      ptr   <= '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      WConflict <= 1'b0;
    end else begin
      WConflict <= wr_ok && en0 && en1 && same_addr;
    end
  end

  // Array has no reset; the sweep clears it and always wins over the ports.
  always_ff @(posedge Clk) begin
    if (!run) begin
      mem[ptr] <= '0;
    end else if (!Init) begin
      if (en0 && !(en1 && same_addr)) begin
        mem[WAddr0] <= WData0;
      end
      if (en1) begin
        mem[WAddr1] <= WData1;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    RData = '0;
    ra    = '0;
    rd    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = RAddr[k*ADDR_W +: ADDR_W];
      rd = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_ok && en1 && WAddr1 == ra) begin
        rd = WData1;
      end else if (wr_ok && en0 && WAddr0 == ra) begin
        rd = WData0;
      end
`endif
      if (!run || (ZERO_REG != 0 && ra == '0)) begin
        rd = '0;
      end
      RData[k*DATA_W +: DATA_W] = rd;
    end
  end

endmodule
